// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Request/acknowledge handshake between the multi-cycle
//                control FSM and the unified instruction/data memory.
//  Signals     : mem_req  - access request, held until mem_ack
//                mem_we   - write qualifier for mem_req
//                iord     - address select (0 = PC, 1 = ALUOut)
//                mem_ack  - access completion (may coincide with mem_req)
//  Modports    : master (controller side), slave (memory side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM of the multi-cycle RV32 datapath. Sequences
//                fetch/decode/execute/memory/writeback for lw, sw, R-type and
//                beq, drives all datapath strobes and mux selects, and counts
//                retired instructions.
//  Ports       : clk, rst      - rising-edge clock, synchronous active-high reset
//                mem           - memory handshake (master modport)
//                opcode, zero  - IR[6:0] and ALU zero flag
//                ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
//                reg_write, mem_to_reg - datapath controls
//                state_o       - current state encoding
//                instret       - retired-instruction counter
//                illegal_insn  - trap flag
//  Config      : ILLEGAL_TRAP_EN - when defined, unknown opcodes enter a
//                sticky TRAP state; otherwise they retire as NOPs.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  mem,
  input  logic [6:0]         opcode,
  input  logic               zero,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic [3:0]         state_o,
  output logic [31:0]        instret,
  output logic               illegal_insn
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8
`ifdef ILLEGAL_TRAP_EN
    ,TRAP  = 4'd9
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state, state_nxt;
  logic   retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      instret <= 32'd0;
    end else begin
      state <= state_nxt;
      if (retire) instret <= instret + 32'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    retire       = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.iord     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    illegal_insn = 1'b0;

    case (state)
      FETCH: begin
        // PC+4 is computed while the instruction is read; both IR and PC
        // load in the ack cycle so a zero-wait fetch takes one cycle.
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        ir_write    = mem.mem_ack;
        pc_write    = mem.mem_ack;
        if (mem.mem_ack) state_nxt = DECODE;
      end
      DECODE: begin
        // oldPC + imm: branch target parked in ALUOut for BRANCH
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXEC;
          OP_BRANCH:         state_nxt = BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_nxt = TRAP;
`else
            state_nxt = FETCH;
            retire    = 1'b1;
`endif
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        // opcode[5] separates store (0100011) from load (0000011)
        state_nxt = opcode[5] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ack) state_nxt = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = FETCH;
        retire     = 1'b1;
      end
      MEMWR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ack) begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end
      end
      EXEC: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = 2'b10;
        state_nxt = RWB;
      end
      RWB: begin
        reg_write = 1'b1;
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      BRANCH: begin
        // regA - regB compare; taken branch loads the target from ALUOut
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
        state_nxt = FETCH;
        retire    = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        illegal_insn = 1'b1;
        state_nxt    = TRAP;
      end
`endif
      default: state_nxt = FETCH;
    endcase

    // Reset cycle: no side effects reach memory, PC, IR or register file.
    if (rst) begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl. Inputs are
//                driven and outputs sampled just after the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        zero;
  logic        ir_write, pc_write, pc_src, reg_write, mem_to_reg, illegal_insn;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic [3:0]  state_o;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl_if mem ();

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (mem.master),
    .opcode       (opcode),
    .zero         (zero),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .state_o      (state_o),
    .instret      (instret),
    .illegal_insn (illegal_insn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, then check state_o.
  task automatic step(input logic r, input logic ack, input logic z, input logic [3:0] exp_state, input string tag);
    @(negedge clk);
    rst         = r;
    mem.mem_ack = ack;
    zero        = z;
    #1;
    chk({tag, ".state"}, {28'd0, state_o}, {28'd0, exp_state});
  endtask

  initial begin
    rst = 1'b1; mem.mem_ack = 1'b1; zero = 1'b0; opcode = 7'b0000011;

    // ---------------- reset: two cycles with ack high ----------------
    step(1, 1, 0, 4'd0, "rst0");
    chk("rst0.mem_req", {31'd0, mem.mem_req}, 0);
    chk("rst0.ir_write", {31'd0, ir_write}, 0);
    chk("rst0.pc_write", {31'd0, pc_write}, 0);
    step(1, 1, 0, 4'd0, "rst1");
    chk("rst1.instret", instret, 0);
    chk("rst1.reg_write", {31'd0, reg_write}, 0);

    // ---------------- lw, zero-wait: 0,1,2,3,4 then FETCH ----------------
    step(0, 1, 0, 4'd0, "lw.f");
    chk("lw.f.mem_req", {31'd0, mem.mem_req}, 1);
    chk("lw.f.ir_write", {31'd0, ir_write}, 1);
    chk("lw.f.pc_write", {31'd0, pc_write}, 1);
    chk("lw.f.srcb", {30'd0, alu_src_b}, 2'b01);
    chk("lw.f.iord", {31'd0, mem.iord}, 0);
    step(0, 0, 0, 4'd1, "lw.d");
    chk("lw.d.srca", {30'd0, alu_src_a}, 2'b01);
    chk("lw.d.srcb", {30'd0, alu_src_b}, 2'b10);
    chk("lw.d.mem_req", {31'd0, mem.mem_req}, 0);
    step(0, 0, 0, 4'd2, "lw.ma");
    chk("lw.ma.srca", {30'd0, alu_src_a}, 2'b10);
    chk("lw.ma.reg_write", {31'd0, reg_write}, 0);
    step(0, 1, 0, 4'd3, "lw.rd");
    chk("lw.rd.mem_req", {31'd0, mem.mem_req}, 1);
    chk("lw.rd.iord", {31'd0, mem.iord}, 1);
    chk("lw.rd.mem_we", {31'd0, mem.mem_we}, 0);
    chk("lw.rd.reg_write", {31'd0, reg_write}, 0);
    step(0, 0, 0, 4'd4, "lw.wb");
    chk("lw.wb.reg_write", {31'd0, reg_write}, 1);
    chk("lw.wb.mem_to_reg", {31'd0, mem_to_reg}, 1);

    // ---------------- sw with 3-cycle ack delay ----------------
    opcode = 7'b0100011;
    step(0, 0, 0, 4'd0, "sw.fwait");      // fetch stall holds FETCH
    chk("lw.instret", instret, 1);
    chk("sw.fwait.ir_write", {31'd0, ir_write}, 0);
    step(0, 1, 0, 4'd0, "sw.f");
    step(0, 0, 0, 4'd1, "sw.d");
    step(0, 0, 0, 4'd2, "sw.ma");
    for (int i = 0; i < 3; i++) begin
      step(0, (i == 2), 0, 4'd5, "sw.wr");
      chk("sw.wr.req", {29'd0, mem.mem_req, mem.mem_we, mem.iord}, 3'b111);
      chk("sw.wr.reg_write", {31'd0, reg_write}, 0);
    end

    // ---------------- beq taken ----------------
    opcode = 7'b1100011;
    step(0, 1, 0, 4'd0, "beq1.f");
    chk("sw.instret", instret, 2);
    step(0, 0, 0, 4'd1, "beq1.d");
    step(0, 0, 1, 4'd8, "beq1.br");
    chk("beq1.pc_write", {31'd0, pc_write}, 1);
    chk("beq1.pc_src", {31'd0, pc_src}, 1);
    chk("beq1.alu_op", {30'd0, alu_op}, 2'b01);

    // ---------------- beq not taken ----------------
    step(0, 1, 0, 4'd0, "beq0.f");
    chk("beq1.instret", instret, 3);
    step(0, 0, 1, 4'd1, "beq0.d");          // zero ignored outside BRANCH
    chk("beq0.d.pc_write", {31'd0, pc_write}, 0);
    step(0, 0, 0, 4'd8, "beq0.br");
    chk("beq0.pc_write", {31'd0, pc_write}, 0);

    // ---------------- R-type ----------------
    opcode = 7'b0110011;
    step(0, 1, 0, 4'd0, "r.f");
    chk("beq0.instret", instret, 4);
    step(0, 1, 0, 4'd1, "r.d");             // ack ignored in DECODE
    step(0, 0, 0, 4'd6, "r.ex");
    chk("r.ex.alu_op", {30'd0, alu_op}, 2'b10);
    chk("r.ex.srca", {30'd0, alu_src_a}, 2'b10);
    step(0, 0, 0, 4'd7, "r.wb");
    chk("r.wb.reg_write", {31'd0, reg_write}, 1);
    chk("r.wb.mem_to_reg", {31'd0, mem_to_reg}, 0);

    // ---------------- illegal opcode ----------------
    opcode = 7'b1111111;
    step(0, 1, 0, 4'd0, "ill.f");
    chk("r.instret", instret, 5);
    step(0, 0, 0, 4'd1, "ill.d");
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 4'd9, "ill.trap");
      chk("ill.trap.flag", {31'd0, illegal_insn}, 1);
      chk("ill.trap.mem_req", {31'd0, mem.mem_req}, 0);
      chk("ill.trap.instret", instret, 5);
    end
    step(1, 1, 0, 4'd9, "ill.rst");
    step(0, 1, 0, 4'd0, "ill.after");
    chk("ill.after.instret", instret, 0);
`else
    step(0, 1, 0, 4'd0, "ill.nop");
    chk("ill.nop.instret", instret, 6);
    chk("ill.nop.flag", {31'd0, illegal_insn}, 0);
`endif

    // ---------------- reset during MEMRD stall ----------------
    opcode = 7'b0000011;
    step(0, 0, 0, 4'd1, "mr.d");
    step(0, 0, 0, 4'd2, "mr.ma");
    step(0, 0, 0, 4'd3, "mr.rd0");
    step(0, 0, 0, 4'd3, "mr.rd1");
    chk("mr.rd1.mem_req", {31'd0, mem.mem_req}, 1);
    step(1, 0, 0, 4'd3, "mr.rst");
    chk("mr.rst.mem_req", {31'd0, mem.mem_req}, 0);
    step(0, 0, 0, 4'd0, "mr.after");
    chk("mr.after.instret", instret, 0);
    chk("mr.after.mem_req", {31'd0, mem.mem_req}, 1);
    chk("mr.after.iord", {31'd0, mem.iord}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle RV32 datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select, and generates the 2-bit `alu_op` consumed by the ALU control decoder, which expands it with func7/func3 into the 4-bit ALU operation. It handles lw, sw, R-type (add/sub/and/or) and beq, and uses a req/ack handshake toward the unified instruction/data memory.

## Interface
- No parameters.
- Clock is `clk` and reset is `rst`: one clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: IR[6:0]; valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ack` in 1: memory completion; may be asserted in the same cycle as `mem_req`.
- `mem_req` out 1: memory access request, held until `mem_ack`.
- `mem_we` out 1: write qualifier for `mem_req`.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR.
- `pc_write` out 1: load PC.
- `pc_src` out 1: PC source; 0 = ALU result, 1 = ALUOut.
- `alu_src_a` out 2: 00 = PC, 01 = oldPC, 10 = regA.
- `alu_src_b` out 2: 00 = regB, 01 = constant 4, 10 = immediate.
- `alu_op` out 2: 00 = add, 01 = sub (compare), 10 = decode by funct.
- `reg_write` out 1: register file write enable.
- `mem_to_reg` out 1: writeback source; 0 = ALUOut, 1 = MDR.
- `state_o` out 4: current state encoding.
- `instret` out 32: retired-instruction counter.
- `illegal_insn` out 1: trap flag; tied 0 unless `ILLEGAL_TRAP_EN` is defined.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, TRAP=9.
- All selects are Moore, decoded from state. Unlisted selects are 0 and unlisted strobes are 0.
- **FETCH**
  - Outputs: `mem_req`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00, `pc_src`=0.
  - `ir_write` = `pc_write` = `mem_ack` (Mealy on ack).
  - Stays in FETCH while `mem_ack`=0; on ack, goes to DECODE.
- **DECODE**
  - Outputs: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00. This computes the branch target into ALUOut.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXEC; 1100011 → BRANCH.
  - Any other opcode → see Configuration.
- **MEMADR**: `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00. Next state is MEMRD if opcode[5]=0, otherwise MEMWR.
- **MEMRD**: `mem_req`=1, `iord`=1. Waits for `mem_ack`, then goes to MEMWB.
- **MEMWB**: `reg_write`=1, `mem_to_reg`=1. Next state is FETCH.
- **MEMWR**: `mem_req`=1, `mem_we`=1, `iord`=1. Waits for `mem_ack`, then goes to FETCH.
- **EXEC**: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next state is RWB.
- **RWB**: `reg_write`=1, `mem_to_reg`=0. Next state is FETCH.
- **BRANCH**
  - Outputs: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `pc_src`=1.
  - `pc_write` = `zero` (Mealy).
  - Next state is FETCH.
- **Retirement**
  - `instret` increments by 1, wrapping at 2^32, on every transition into FETCH from MEMWB, MEMWR with ack, RWB or BRANCH.
  - It also increments on the illegal-NOP path (DECODE → FETCH).
- **Stalls**: the `mem_req`, `iord` and `mem_we` values stay constant for every cycle of a wait state. `mem_ack` outside FETCH, MEMRD and MEMWR is ignored.

## Timing
- **Reset**
  - A cycle with `rst`=1 loads state FETCH and `instret`=0.
  - During any cycle with `rst`=1, `mem_req`, `mem_we`, `ir_write`, `pc_write` and `reg_write` are forced to 0.
  - First fetch request: the first cycle after `rst` deasserts.
  - Reset mid-operation (including during a memory wait) abandons the instruction. `mem_req` drops in the reset cycle, and the interrupted instruction does not count in `instret`.
- **Latency with zero-wait memory** (`mem_ack` in the request cycle): lw 5 cycles, sw 4, R-type 4, beq 3. Each memory wait cycle adds 1.
- `mem_ack` in the same cycle as `mem_req` completes that access; no extra cycle is inserted.
- `zero` is sampled only in BRANCH, and only combinationally into `pc_write`.

## Configuration
- Macro: `ILLEGAL_TRAP_EN`.
- **Defined**
  - An unrecognised opcode in DECODE goes to TRAP.
  - TRAP drives all strobes 0 and holds `illegal_insn`=1.
  - It stays in TRAP until `rst`; `instret` does not increment.
- **Undefined**
  - An unrecognised opcode is a NOP: DECODE → FETCH, `instret` increments.
  - `illegal_insn` is constant 0 and the TRAP state is not built.

## Test plan
- **Reset/fetch**: assert `rst` for 2 cycles with `mem_ack`=1, then release.
  - `state_o` goes 0 → 1 on consecutive cycles.
  - `ir_write`=`pc_write`=1 in the FETCH cycle.
  - `instret`=0.
- **lw, zero-wait**: opcode 0000011.
  - State sequence 0, 1, 2, 3, 4, 0.
  - `reg_write`=`mem_to_reg`=1 only in state 4.
  - `instret` becomes 1.
- **sw with 3-cycle ack delay**: opcode 0100011.
  - MEMWR is held 3 cycles with `mem_req`=`mem_we`=`iord`=1 constant.
  - Then FETCH; no `reg_write` at any point.
- **beq**: opcode 1100011.
  - With `zero`=1: `pc_write`=1, `pc_src`=1, `alu_op`=01 in BRANCH.
  - With `zero`=0: `pc_write`=0.
  - Both cases take 3 cycles.
- **R-type**: opcode 0110011. `alu_op`=10 in EXEC, then `reg_write`=1, `mem_to_reg`=0 in RWB; 4 cycles.
- **Illegal opcode 1111111 and mid-wait reset**
  - With the macro defined: `illegal_insn`=1 and the FSM stays in state 9 until reset.
  - With the macro undefined: next state is FETCH and `instret` increments.
  - `rst` during a MEMRD stall: next state is 0, `mem_req`=0 in the reset cycle.
